sram_req_arbiter: RTL and testbench
===================================

// Module: sram_req_arbiter
// PURPOSE
// Shares one SRAM-like request port, feeding the AXI bridge, between the inst-fetch and data-access requesters.
// Priority is data > inst, with an anti-starvation override. A grant is held until out_addr_ok.
// Return routing is in order, via an owner FIFO. Total outstanding transactions are capped.
// Data reads are blocked while any data write is outstanding (RAW ordering).
// PARAMETERS
// MAX_OUTST   4  max accepted-but-unreturned transactions (power of 2, 2..8); owner FIFO depth
// STARVE_LIM  3  consecutive data grants while inst_req pending, after which inst wins the next arbitration
// PORTS
// clk                                    in   1    clock, all state on posedge
// reset                                  in   1    synchronous, active-high reset
// inst_req/inst_wr/inst_size             in   1/1/2    inst requester request, write flag, size (log2 bytes)
// inst_addr/inst_wstrb/inst_wdata        in   32/4/32  inst requester address, byte strobe, write data
// inst_addr_ok/inst_data_ok              out  1/1      inst request accepted / inst response done
// inst_rdata                             out  32       inst read data (valid with inst_data_ok)
// data_req/data_wr/data_size             in   1/1/2    data requester, same meaning as inst_*
// data_addr/data_wstrb/data_wdata        in   32/4/32  data requester, same meaning as inst_*
// data_addr_ok/data_data_ok/data_rdata   out  1/1/32   data requester, same meaning as inst_*
// out_req/out_wr/out_size                out  1/1/2    request to bridge
// out_addr/out_wstrb/out_wdata           out  32/4/32  request to bridge
// out_addr_ok/out_data_ok                in   1/1      bridge accept / bridge response (in issue order)
// out_rdata                              in   32       bridge read data
// BEHAVIOUR
// - State machine: IDLE, GNT_I, GNT_D. Reset -> IDLE; cnt=0, FIFO empty, wr_cnt=0, starve=0.
// - Eligibility: inst eligible = inst_req & cnt<MAX_OUTST.
// - Eligibility: data eligible = data_req & cnt<MAX_OUTST & (data_wr | wr_cnt==0).
// - IDLE: pick data if eligible, unless starve==STARVE_LIM and inst is eligible; otherwise pick inst.
// - The pick is registered into GNT_D/GNT_I, so out_req asserts 1 cycle after the pick.
// - GNT_x: out_* driven from requester x, out_req=1. On out_addr_ok, x_addr_ok=1 (combinational pass-through).
// - GNT_x on handshake: push owner bit (1=data) and the wr flag to the FIFO, then return to IDLE.
// - Other requester's addr_ok stays 0. A grant is never withdrawn before out_addr_ok.
// - Requesters hold req and payload stable until their addr_ok.
// - starve: +1 on each data handshake while inst_req=1; cleared on an inst handshake; saturates at STARVE_LIM.
// - Return path: on out_data_ok, route to the owner at the FIFO head and pop.
// - Return path: x_data_ok = out_data_ok & (head==x); both rdata outputs = out_rdata.
// - Counters: cnt +1 on handshake, -1 on out_data_ok; a simultaneous push+pop leaves cnt unchanged.
// - Counters: wr_cnt tracks outstanding data writes the same way (popped entry's wr flag).
// - Overflow/underflow: out_data_ok with an empty FIFO is a protocol error (assertion), and cnt is not decremented.
// - Full: cnt==MAX_OUTST is never exceeded; a handshake is impossible because no grant is issued.
// - Reset mid-operation: all state is cleared at once and outputs return to 0 next cycle. In-flight returns are dropped.
// - Reset values: every output is 0 (rdata outputs follow out_rdata; they are don't-care while data_ok=0).
// TESTING
// - Inst only, out_addr_ok after 2 cycles -> inst_addr_ok pulses once; out_data_ok -> inst_data_ok=1, rdata=0x1C000000.
// - Both requesters reading simultaneously -> data granted first, inst next; in-order returns go data then inst.
// - Data write to 0x100 outstanding, then a data read -> no grant until the write's data_ok; read issued the cycle after.
// - Data_req held high with inst_req high -> after 3 data handshakes, inst is granted next; starve resets to 0.
// - MAX_OUTST=4, bridge withholds data_ok -> 4 accepted, out_req stays 0; one data_ok -> 5th accepted, cnt stays 4.
// - Reset asserted with 2 outstanding and a grant pending -> all outputs 0 next cycle; later out_data_ok is ignored.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like request port between inst-fetch and data-access requesters.
// Data wins by default; inst is forced through after STARVE_LIM back-to-back data grants.
module sram_req_arbiter #(
    parameter int MAX_OUTST  = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        out_req,
    output logic        out_wr,
    output logic [1:0]  out_size,
    output logic [31:0] out_addr,
    output logic [3:0]  out_wstrb,
    output logic [31:0] out_wdata,
    input  logic        out_addr_ok,
    input  logic        out_data_ok,
    input  logic [31:0] out_rdata
);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        wr_cnt;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [MAX_OUTST-1:0] own_q;   // 1 = data requester
    logic [MAX_OUTST-1:0] dwr_q;   // entry is a data write
    logic [SW-1:0]        starve;

    logic hs, hs_data, push_dwr, fifo_nonempty, pop, pop_dwr, head_data;
    logic room, inst_elig, data_elig;

    assign hs            = (state != IDLE) && out_addr_ok;
    assign hs_data       = hs && (state == GNT_D);
    assign push_dwr      = hs_data && data_wr;
    assign fifo_nonempty = (cnt != '0);
    assign pop           = out_data_ok && fifo_nonempty;
    assign head_data     = own_q[rd_ptr];
    assign pop_dwr       = pop && dwr_q[rd_ptr];

    assign room      = (cnt < CW'(MAX_OUTST));
    assign inst_elig = inst_req && room;
    // RAW ordering: a data read must not pass an outstanding data write
    assign data_elig = data_req && room && (data_wr || (wr_cnt == '0));

    assign inst_addr_ok = (state == GNT_I) && out_addr_ok;
    assign data_addr_ok = (state == GNT_D) && out_addr_ok;
    assign inst_data_ok = pop && !head_data;
    assign data_data_ok = pop && head_data;
    assign inst_rdata   = out_rdata;
    assign data_rdata   = out_rdata;

    always_comb begin
        out_req   = 1'b0;
        out_wr    = 1'b0;
        out_size  = '0;
        out_addr  = '0;
        out_wstrb = '0;
        out_wdata = '0;
        case (state)
            GNT_I: begin
                out_req   = 1'b1;
                out_wr    = inst_wr;
                out_size  = inst_size;
                out_addr  = inst_addr;
                out_wstrb = inst_wstrb;
                out_wdata = inst_wdata;
            end
            GNT_D: begin
                out_req   = 1'b1;
                out_wr    = data_wr;
                out_size  = data_size;
                out_addr  = data_addr;
                out_wstrb = data_wstrb;
                out_wdata = data_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            wr_cnt <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            own_q  <= '0;
            dwr_q  <= '0;
            starve <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((starve == SW'(STARVE_LIM)) && inst_elig) state <= GNT_I;
                    else if (data_elig)                          state <= GNT_D;
                    else if (inst_elig)                          state <= GNT_I;
                end
                GNT_I, GNT_D: if (out_addr_ok) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (hs) begin
                own_q[wr_ptr] <= hs_data;
                dwr_q[wr_ptr] <= push_dwr;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);

            cnt    <= cnt + CW'(hs) - CW'(pop);
            wr_cnt <= wr_cnt + CW'(push_dwr) - CW'(pop_dwr);

            if (hs && (state == GNT_I))
                starve <= '0;
            else if (hs_data && inst_req && (starve != SW'(STARVE_LIM)))
                starve <= starve + SW'(1);
        end
    end

    // A return with nothing outstanding means the bridge broke ordering
    always_ff @(posedge clk) begin
        if (!reset) assert (!(out_data_ok && !fifo_nonempty))
            else $error("sram_req_arbiter: out_data_ok with no outstanding transaction");
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios with literal expectations, then random
// traffic, all watched by a transaction-level model (queue of outstanding owners).
module tb_sram_req_arbiter;
    localparam int MAX = 4;
    localparam int LIM = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        out_req, out_wr, out_addr_ok, out_data_ok;
    logic [1:0]  out_size;
    logic [31:0] out_addr, out_wdata, out_rdata;
    logic [3:0]  out_wstrb;

    sram_req_arbiter #(.MAX_OUTST(MAX), .STARVE_LIM(LIM)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .out_req(out_req), .out_wr(out_wr), .out_size(out_size), .out_addr(out_addr),
        .out_wstrb(out_wstrb), .out_wdata(out_wdata), .out_addr_ok(out_addr_ok),
        .out_data_ok(out_data_ok), .out_rdata(out_rdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who holds the grant (0 none, 1 inst, 2 data) and the outstanding transactions in issue order
    typedef struct packed { logic own; logic wr; } ent_t;
    ent_t mq[$];
    int   mg = 0;
    int   mstarve = 0;
    int   order[$];              // accepted requester per handshake: 0 inst, 1 data
    logic inst_acc = 1'b0, data_acc = 1'b0;
    logic drop_i = 1'b1, drop_d = 1'b1;

    logic        e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    int          nwr, nxt;
    logic        ie, de, dpop, dpush;
    ent_t        ne;

    always @(negedge clk) begin
        e_req = (mg != 0);
        e_wr = 1'b0; e_size = '0; e_addr = '0; e_wstrb = '0; e_wdata = '0;
        if (mg == 1) begin
            e_wr = inst_wr; e_size = inst_size; e_addr = inst_addr; e_wstrb = inst_wstrb; e_wdata = inst_wdata;
        end else if (mg == 2) begin
            e_wr = data_wr; e_size = data_size; e_addr = data_addr; e_wstrb = data_wstrb; e_wdata = data_wdata;
        end
        e_iaok = (mg == 1) && out_addr_ok;
        e_daok = (mg == 2) && out_addr_ok;
        e_idok = out_data_ok && (mq.size() > 0) && !mq[0].own;
        e_ddok = out_data_ok && (mq.size() > 0) && mq[0].own;
        chk("m_out_req", out_req, e_req);
        chk("m_out_wr", out_wr, e_wr);
        chk("m_out_size", out_size, e_size);
        chk("m_out_addr", out_addr, e_addr);
        chk("m_out_wstrb", out_wstrb, e_wstrb);
        chk("m_out_wdata", out_wdata, e_wdata);
        chk("m_inst_addr_ok", inst_addr_ok, e_iaok);
        chk("m_data_addr_ok", data_addr_ok, e_daok);
        chk("m_inst_data_ok", inst_data_ok, e_idok);
        chk("m_data_data_ok", data_data_ok, e_ddok);
        if (e_idok) chk("m_inst_rdata", inst_rdata, out_rdata);
        if (e_ddok) chk("m_data_rdata", data_rdata, out_rdata);

        inst_acc = inst_addr_ok;
        data_acc = data_addr_ok;
        if (inst_addr_ok) order.push_back(0);
        if (data_addr_ok) order.push_back(1);

        if (reset) begin
            mq.delete();
            mg = 0;
            mstarve = 0;
        end else begin
            nwr = 0;
            foreach (mq[i]) if (mq[i].own && mq[i].wr) nwr++;
            ie = inst_req && (mq.size() < MAX);
            de = data_req && (mq.size() < MAX) && (data_wr || nwr == 0);
            dpop  = out_data_ok && (mq.size() > 0);
            dpush = 1'b0;
            nxt = mg;
            if (mg == 0) begin
                if (mstarve == LIM && ie) nxt = 1;
                else if (de)              nxt = 2;
                else if (ie)              nxt = 1;
            end else if (out_addr_ok) begin
                dpush = 1'b1;
                ne.own = (mg == 2);
                ne.wr  = (mg == 2) ? data_wr : inst_wr;
                if (mg == 1) mstarve = 0;
                else if (inst_req && mstarve < LIM) mstarve++;
                nxt = 0;
            end
            if (dpop) void'(mq.pop_front());
            if (dpush) mq.push_back(ne);
            mg = nxt;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        if (inst_acc && drop_i) inst_req = 1'b0;
        if (data_acc && drop_d) data_req = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            out_data_ok = 1'b1;
            out_rdata = $urandom;
            tick();
        end
        out_data_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        out_addr_ok = 0; out_data_ok = 0; out_rdata = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_req", out_req, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        tick();

        // inst only, bridge accepts two cycles after the request appears
        order.delete();
        inst_req = 1; inst_addr = 32'h1C000000;
        @(negedge clk) chk("t1_pick_cycle", out_req, 0);
        tick();
        @(negedge clk);
        chk("t1_out_req", out_req, 1);
        chk("t1_out_addr", out_addr, 32'h1C000000);
        tick(); tick(); out_addr_ok = 1;
        @(negedge clk);
        chk("t1_inst_addr_ok", inst_addr_ok, 1);
        chk("t1_data_addr_ok", data_addr_ok, 0);
        tick(); out_addr_ok = 0;
        @(negedge clk);
        chk("t1_released", out_req, 0);
        chk("t1_one_pulse", order.size(), 1);
        tick(); out_data_ok = 1; out_rdata = 32'h1C000000;
        @(negedge clk);
        chk("t1_inst_data_ok", inst_data_ok, 1);
        chk("t1_data_data_ok", data_data_ok, 0);
        chk("t1_inst_rdata", inst_rdata, 32'h1C000000);
        tick(); out_data_ok = 0;

        // simultaneous reads: data first, returns in the same order
        order.delete(); out_addr_ok = 1;
        inst_req = 1; inst_addr = 32'h2000; data_req = 1; data_wr = 0; data_addr = 32'h3000;
        repeat (6) tick();
        out_addr_ok = 0;
        chk("t2_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("t2_first_data", order[0], 1);
            chk("t2_second_inst", order[1], 0);
        end
        out_data_ok = 1; out_rdata = 32'h000000D0;
        @(negedge clk);
        chk("t2_ret0_data", data_data_ok, 1);
        chk("t2_ret0_not_inst", inst_data_ok, 0);
        tick(); out_rdata = 32'h00000010;
        @(negedge clk);
        chk("t2_ret1_inst", inst_data_ok, 1);
        chk("t2_ret1_rdata", inst_rdata, 32'h00000010);
        tick(); out_data_ok = 0;

        // data write outstanding blocks a following data read
        order.delete(); out_addr_ok = 1;
        data_req = 1; data_wr = 1; data_addr = 32'h100; data_wstrb = 4'hF; data_wdata = 32'hCAFE;
        tick(); tick();
        data_req = 1; data_wr = 0; data_addr = 32'h104; data_wstrb = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) chk("t3_blocked", out_req, 0);
            tick();
        end
        out_data_ok = 1;
        @(negedge clk);
        chk("t3_write_ret", data_data_ok, 1);
        tick(); out_data_ok = 0;
        @(negedge clk) chk("t3_pick_cycle", out_req, 0);
        tick();
        @(negedge clk);
        chk("t3_read_issued", out_req, 1);
        chk("t3_read_addr", out_addr, 32'h104);
        chk("t3_read_wr", out_wr, 0);
        tick();
        drain(1);

        // starvation: 3 data handshakes with inst pending, then inst
        order.delete(); drop_d = 0; out_addr_ok = 1;
        inst_req = 1; inst_addr = 32'h4000; data_req = 1; data_wr = 0; data_addr = 32'h5000;
        repeat (8) tick();
        chk("t4_count", order.size(), 4);
        if (order.size() >= 4) begin
            chk("t4_d0", order[0], 1);
            chk("t4_d1", order[1], 1);
            chk("t4_d2", order[2], 1);
            chk("t4_inst", order[3], 0);
        end
        out_data_ok = 1; tick(); out_data_ok = 0;
        tick(); tick();
        data_req = 0; drop_d = 1;
        chk("t4_after_count", order.size(), 5);
        if (order.size() >= 5) chk("t4_data_again", order[4], 1);
        drain(4);

        // outstanding cap
        order.delete(); drop_i = 0; out_addr_ok = 1;
        inst_req = 1; inst_addr = 32'h6000;
        repeat (12) tick();
        chk("t5_four_accepted", order.size(), 4);
        @(negedge clk) chk("t5_no_req_full", out_req, 0);
        tick(); out_data_ok = 1; tick(); out_data_ok = 0;
        repeat (6) tick();
        chk("t5_fifth_accepted", order.size(), 5);
        @(negedge clk) chk("t5_still_full", out_req, 0);
        tick(); inst_req = 0;
        drain(4);

        // reset with two outstanding and a grant pending
        order.delete(); inst_req = 1; inst_addr = 32'h7000; out_addr_ok = 1;
        repeat (4) tick();
        out_addr_ok = 0;
        tick();
        reset = 1;
        @(negedge clk) chk("t6_grant_pending", out_req, 1);
        tick(); reset = 0; inst_req = 0;
        @(negedge clk);
        chk("t6_out_req", out_req, 0);
        chk("t6_out_addr", out_addr, 0);
        chk("t6_inst_addr_ok", inst_addr_ok, 0);
        chk("t6_data_addr_ok", data_addr_ok, 0);
        chk("t6_inst_data_ok", inst_data_ok, 0);
        chk("t6_data_data_ok", data_data_ok, 0);
        tick();
        order.delete(); inst_req = 1; out_addr_ok = 1;
        repeat (12) tick();
        chk("t6_cnt_cleared", order.size(), 4);
        inst_req = 0; drop_i = 1;
        drain(4);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req = 1; inst_wr = $urandom_range(0, 3) == 0; inst_size = 2'($urandom);
                inst_addr = $urandom; inst_wstrb = 4'($urandom); inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req = 1; data_wr = $urandom_range(0, 4) < 2; data_size = 2'($urandom);
                data_addr = $urandom; data_wstrb = 4'($urandom); data_wdata = $urandom;
            end
            out_addr_ok = 1'($urandom);
            out_data_ok = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
            out_rdata = $urandom;
            reset = ($urandom_range(0, 399) == 0);
        end
        reset = 0; out_addr_ok = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            out_data_ok = (mq.size() > 0);
            out_rdata = $urandom;
        end
        out_data_ok = 0;
        @(negedge clk) chk("end_idle", out_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
